// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 keyboard receiver.
// Frame geometry, receive FSM states and the scancode type.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;
    // start, parity and stop surround the payload
    localparam int PS2_DATA_BITS = PS2_FRAME_BITS - 3;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    typedef logic [7:0] scancode_t;

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports: push/wdata in, pop in, rdata (head, 0 when empty), full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a pop frees the slot, so a push into a full FIFO still fits
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with deglitch, watchdog and scancode FIFO.
// Ports: clk, clrn, ps2_clk/ps2_data pins, rdn pop, clr_err; data/ready/count, overflow, frame_err.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int SYNC_STG    = 2,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       ps2_clk,
    input  logic                       ps2_data,
    input  logic                       rdn,
    input  logic                       clr_err,
    output logic [7:0]                 data,
    output logic                       ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       frame_err
);

    localparam int FW = $clog2(FILT_LEN);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    // pins idle high, so the chains start at 1 to avoid a false fall
    logic [SYNC_STG-1:0] clk_sync;
    logic [SYNC_STG-1:0] dat_sync;
    logic                clk_s;
    logic                bit_s;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STG-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STG-2:0], ps2_data};
        end
    end

    assign clk_s = clk_sync[SYNC_STG-1];
    assign bit_s = dat_sync[SYNC_STG-1];

    // filt_cnt counts consecutive samples that disagree with the level
    logic          filt_lvl;
    logic [FW-1:0] filt_cnt;
    logic          filt_flip;
    logic          fall;

    assign filt_flip = (clk_s != filt_lvl) && (filt_cnt == FW'(FILT_LEN - 1));
    assign fall      = filt_flip && filt_lvl;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            filt_lvl <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == filt_lvl) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            filt_lvl <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    ps2_state_t    state;
    ps2_state_t    state_n;
    scancode_t     shreg;
    scancode_t     shreg_n;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_n;
    logic          par_ok;
    logic          par_ok_n;
    logic [WW-1:0] wdog;
    logic [WW-1:0] wdog_n;
    logic          timeout;
    logic          push;
    logic          bad_evt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par_ok  <= 1'b0;
            wdog    <= '0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            par_ok  <= par_ok_n;
            wdog    <= wdog_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        par_ok_n  = par_ok;
        push      = 1'b0;
        bad_evt   = 1'b0;
        wdog_n    = (state == IDLE || fall) ? '0 : wdog + 1'b1;
        timeout   = (state != IDLE) && !fall
                    && (wdog == WW'(TIMEOUT_CYC - 1));
        case (state)
            IDLE: begin
                if (fall && !bit_s) begin
                    state_n   = DATA;
                    shreg_n   = '0;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shreg_n   = {bit_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_n = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_ok_n = ^shreg ^ bit_s;
                    state_n  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    if (bit_s && par_ok) push    = 1'b1;
                    else                 bad_evt = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            state_n = IDLE;
            bad_evt = 1'b1;
            push    = 1'b0;
        end
    end

    logic full;
    logic empty;
    logic ovf_evt;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push),
        .wdata (shreg),
        .pop   (!rdn),
        .rdata (data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign ready = !empty;
    // when full, a same-cycle pop makes room, so only push-without-pop drops
    assign ovf_evt = push && full && rdn;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ovf_evt)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (bad_evt)      frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

endmodule
